id_exe_issue: RTL and testbench

ID_EXE_ISSUE -- requirements
Module: id_exe_issue

---
 rtl/id_exe_issue_pkg.sv | 101 ++++++++++
 rtl/id_exe_issue_val2_generator.sv | 39 +++
 rtl/id_exe_issue.sv | 126 ++++++++++++
 tb/tb_id_exe_issue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/id_exe_issue_pkg.sv
// Shared decode constants for the ID/EXE issue stage: ALU commands,
// data-processing opcodes, condition codes, shift types and the
// decoded-control bundle, plus the ARM condition evaluator.
package id_exe_issue_pkg;

    // ALU command encodings driven on exe_cmd
    localparam logic [3:0] EXE_NOP = 4'd0;
    localparam logic [3:0] EXE_MOV = 4'd1;
    localparam logic [3:0] EXE_ADD = 4'd2;
    localparam logic [3:0] EXE_ADC = 4'd3;
    localparam logic [3:0] EXE_SUB = 4'd4;
    localparam logic [3:0] EXE_SBC = 4'd5;
    localparam logic [3:0] EXE_AND = 4'd6;
    localparam logic [3:0] EXE_ORR = 4'd7;
    localparam logic [3:0] EXE_EOR = 4'd8;
    localparam logic [3:0] EXE_MVN = 4'd9;

    // Data-processing opcodes supported by this stage (instr[24:21])
    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_EOR = 4'b0001,
        OP_SUB = 4'b0010,
        OP_ADD = 4'b0100,
        OP_ADC = 4'b0101,
        OP_SBC = 4'b0110,
        OP_TST = 4'b1000,
        OP_CMP = 4'b1010,
        OP_ORR = 4'b1100,
        OP_MOV = 4'b1101,
        OP_MVN = 4'b1111
    } opcode_t;

    // ARM condition field (instr[31:28])
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    // Register-operand shift types (instr[6:5])
    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_t;

    // Control fields produced by the decoder before the condition check
    typedef struct packed {
        logic       valid;
        logic [3:0] exe_cmd;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       s_upd;
        logic       b_taken;
    } ctrl_t;

    // Evaluate an ARM condition code against {N,Z,C,V}; NV never passes
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic pass;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond_t'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/id_exe_issue_val2_generator.sv
// Second ALU operand generator: memory offset, rotated 8-bit immediate,
// or shifted register operand.
module val2_generator
    import id_exe_issue_pkg::*;
(
    input  logic        imm,
    input  logic        mem,
    input  logic [11:0] shift_operand,
    input  logic [31:0] rm_val,
    output logic [31:0] val2
);

    logic [63:0] imm_rot;
    logic [63:0] rm_rot;
    logic [4:0]  shift_amt;
    logic [4:0]  rot_amt;

    // Select and form the operand; a zero shift amount passes rm_val through
    always_comb begin
        rot_amt   = {shift_operand[11:8], 1'b0};
        shift_amt = shift_operand[11:7];
        imm_rot   = {24'd0, shift_operand[7:0], 24'd0, shift_operand[7:0]} >> rot_amt;
        rm_rot    = {rm_val, rm_val} >> shift_amt;
        val2      = rm_val;
        if (mem) begin
            val2 = {20'd0, shift_operand};
        end else if (imm) begin
            val2 = imm_rot[31:0];
        end else if (shift_amt != 5'd0) begin
            case (shift_t'(shift_operand[6:5]))
                SHIFT_LSL: val2 = rm_val << shift_amt;
                SHIFT_LSR: val2 = rm_val >> shift_amt;
                SHIFT_ASR: val2 = $unsigned($signed(rm_val) >>> shift_amt);
                default:   val2 = rm_rot[31:0];
            endcase
        end
    end

endmodule

// File: rtl/id_exe_issue.sv
// ID/EXE issue stage: decodes an ARM instruction, checks its condition,
// builds the ALU operands and registers everything for the execute stage.
module id_exe_issue
    import id_exe_issue_pkg::*;
#(
    parameter int N_REGS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               instr,
    input  logic                      in_valid,
    input  logic [31:0]               rn_val,
    input  logic [31:0]               rm_val,
    input  logic [3:0]                nzcv,
    input  logic                      freeze,
    input  logic                      flush,
    output logic [3:0]                exe_cmd,
    output logic [31:0]               val1,
    output logic [31:0]               val2,
    output logic                      carry,
    output logic                      wb_en,
    output logic                      mem_r_en,
    output logic                      mem_w_en,
    output logic                      s_upd,
    output logic                      b_taken,
    output logic [$clog2(N_REGS)-1:0] dest,
    output logic [23:0]               imm24,
    output logic                      out_valid
);

    localparam int DEST_W = $clog2(N_REGS);

    ctrl_t       ctrl;
    logic        issue;
    logic [31:0] val2_next;

    val2_generator u_val2 (
        .imm           (instr[25]),
        .mem           (instr[27:26] == 2'b01),
        .shift_operand (instr[11:0]),
        .rm_val        (rm_val),
        .val2          (val2_next)
    );

    // Decode instruction class and opcode into ALU command and enables
    always_comb begin
        ctrl = '0;
        case (instr[27:26])
            2'b00: begin
                ctrl.valid = 1'b1;
                ctrl.wb_en = 1'b1;
                ctrl.s_upd = instr[20];
                case (opcode_t'(instr[24:21]))
                    OP_MOV: ctrl.exe_cmd = EXE_MOV;
                    OP_MVN: ctrl.exe_cmd = EXE_MVN;
                    OP_ADD: ctrl.exe_cmd = EXE_ADD;
                    OP_ADC: ctrl.exe_cmd = EXE_ADC;
                    OP_SUB: ctrl.exe_cmd = EXE_SUB;
                    OP_SBC: ctrl.exe_cmd = EXE_SBC;
                    OP_AND: ctrl.exe_cmd = EXE_AND;
                    OP_ORR: ctrl.exe_cmd = EXE_ORR;
                    OP_EOR: ctrl.exe_cmd = EXE_EOR;
                    OP_CMP: begin
                        ctrl.exe_cmd = EXE_SUB;
                        ctrl.wb_en   = 1'b0;
                        ctrl.s_upd   = 1'b1;
                    end
                    OP_TST: begin
                        ctrl.exe_cmd = EXE_AND;
                        ctrl.wb_en   = 1'b0;
                        ctrl.s_upd   = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            2'b01: begin
                ctrl.valid    = 1'b1;
                ctrl.exe_cmd  = EXE_ADD;
                ctrl.mem_r_en = instr[20];
                ctrl.wb_en    = instr[20];
                ctrl.mem_w_en = ~instr[20];
            end
            2'b10: begin
                if (instr[25]) begin
                    ctrl.valid   = 1'b1;
                    ctrl.exe_cmd = EXE_NOP;
                    ctrl.b_taken = 1'b1;
                end
            end
            default: ctrl = '0;
        endcase
        issue = in_valid & ctrl.valid & cond_pass(instr[31:28], nzcv);
    end

    // Output register bank: reset, then flush, then freeze hold, else load
    always_ff @(posedge clk) begin
        if (rst || flush || (!freeze && !issue)) begin
            exe_cmd   <= EXE_NOP;
            val1      <= '0;
            val2      <= '0;
            carry     <= 1'b0;
            wb_en     <= 1'b0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            s_upd     <= 1'b0;
            b_taken   <= 1'b0;
            dest      <= '0;
            imm24     <= '0;
            out_valid <= 1'b0;
        end else if (!freeze) begin
            exe_cmd   <= ctrl.exe_cmd;
            val1      <= rn_val;
            val2      <= val2_next;
            carry     <= nzcv[1];
            wb_en     <= ctrl.wb_en;
            mem_r_en  <= ctrl.mem_r_en;
            mem_w_en  <= ctrl.mem_w_en;
            s_upd     <= ctrl.s_upd;
            b_taken   <= ctrl.b_taken;
            dest      <= instr[12 +: DEST_W];
            imm24     <= ctrl.b_taken ? instr[23:0] : 24'd0;
            out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_exe_issue.sv
// Directed self-checking bench for the ID/EXE issue stage.
module tb_id_exe_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        in_valid;
    logic [31:0] rn_val;
    logic [31:0] rm_val;
    logic [3:0]  nzcv;
    logic        freeze;
    logic        flush;
    logic [3:0]  exe_cmd;
    logic [31:0] val1;
    logic [31:0] val2;
    logic        carry;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        s_upd;
    logic        b_taken;
    logic [3:0]  dest;
    logic [23:0] imm24;
    logic        out_valid;

    int compared   = 0;
    int mismatched = 0;

    id_exe_issue #(.N_REGS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .in_valid  (in_valid),
        .rn_val    (rn_val),
        .rm_val    (rm_val),
        .nzcv      (nzcv),
        .freeze    (freeze),
        .flush     (flush),
        .exe_cmd   (exe_cmd),
        .val1      (val1),
        .val2      (val2),
        .carry     (carry),
        .wb_en     (wb_en),
        .mem_r_en  (mem_r_en),
        .mem_w_en  (mem_w_en),
        .s_upd     (s_upd),
        .b_taken   (b_taken),
        .dest      (dest),
        .imm24     (imm24),
        .out_valid (out_valid)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock it in, then settle past the edge
    task automatic applyStimulus(input logic [31:0] i_instr, input logic i_valid,
                                 input logic [31:0] i_rn, input logic [31:0] i_rm,
                                 input logic [3:0] i_nzcv, input logic i_freeze,
                                 input logic i_flush, input logic i_rst);
        instr    = i_instr;
        in_valid = i_valid;
        rn_val   = i_rn;
        rm_val   = i_rm;
        nzcv     = i_nzcv;
        freeze   = i_freeze;
        flush    = i_flush;
        rst      = i_rst;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Compare the control outputs as a group
    task automatic checkCtrl(input string tag, input logic [3:0] e_cmd, input logic e_wb,
                             input logic e_mr, input logic e_mw, input logic e_s,
                             input logic e_b, input logic e_valid);
        checkOutput({tag, ".exe_cmd"},   {28'd0, exe_cmd},   {28'd0, e_cmd});
        checkOutput({tag, ".wb_en"},     {31'd0, wb_en},     {31'd0, e_wb});
        checkOutput({tag, ".mem_r_en"},  {31'd0, mem_r_en},  {31'd0, e_mr});
        checkOutput({tag, ".mem_w_en"},  {31'd0, mem_w_en},  {31'd0, e_mw});
        checkOutput({tag, ".s_upd"},     {31'd0, s_upd},     {31'd0, e_s});
        checkOutput({tag, ".b_taken"},   {31'd0, b_taken},   {31'd0, e_b});
        checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_valid});
    endtask

    // A bubble has every enable low and zeroed operands and destination
    task automatic checkBubble(input string tag);
        checkCtrl(tag, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, ".val1"}, val1, 32'd0);
        checkOutput({tag, ".val2"}, val2, 32'd0);
        checkOutput({tag, ".dest"}, {28'd0, dest}, 32'd0);
    endtask

    // Directed sequence of instructions with hand-computed results
    initial begin
        $display("[TB] starting id_exe_issue directed test");

        applyStimulus(32'hE29214FF, 1'b1, 32'd5, 32'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
        checkBubble("reset");
        checkOutput("reset.carry", {31'd0, carry}, 32'd0);
        checkOutput("reset.imm24", {8'd0, imm24}, 32'd0);

        applyStimulus(32'hE29214FF, 1'b1, 32'd5, 32'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkCtrl("adds_imm", 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("adds_imm.val1", val1, 32'd5);
        checkOutput("adds_imm.val2", val2, 32'hFF000000);
        checkOutput("adds_imm.dest", {28'd0, dest}, 32'd1);

        applyStimulus(32'hE0410222, 1'b1, 32'd7, 32'h80000000, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkCtrl("sub_lsr", 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("sub_lsr.val1", val1, 32'd7);
        checkOutput("sub_lsr.val2", val2, 32'h08000000);
        checkOutput("sub_lsr.dest", {28'd0, dest}, 32'd0);

        applyStimulus(32'hE0410242, 1'b1, 32'd7, 32'h80000000, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("sub_asr.val2", val2, 32'hF8000000);
        checkOutput("sub_asr.exe_cmd", {28'd0, exe_cmd}, 32'd4);

        applyStimulus(32'hE1A00462, 1'b1, 32'd0, 32'h000000AB, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("mov_ror.val2", val2, 32'hAB000000);
        checkOutput("mov_ror.exe_cmd", {28'd0, exe_cmd}, 32'd1);

        applyStimulus(32'hE1510002, 1'b1, 32'd9, 32'd3, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkCtrl("cmp", 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("cmp.val2", val2, 32'd3);

        applyStimulus(32'h00810002, 1'b1, 32'd1, 32'd2, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkBubble("eq_fail");

        applyStimulus(32'h00810002, 1'b1, 32'd1, 32'd2, 4'b0100, 1'b0, 1'b0, 1'b0);
        checkCtrl("eq_pass", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("eq_pass.val2", val2, 32'd2);

        applyStimulus(32'hF0810002, 1'b1, 32'd1, 32'd2, 4'b1111, 1'b0, 1'b0, 1'b0);
        checkBubble("cond_nv");

        applyStimulus(32'hE0610002, 1'b1, 32'd1, 32'd2, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkBubble("rsb_unlisted");

        applyStimulus(32'hE0810002, 1'b0, 32'd1, 32'd2, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkBubble("in_invalid");

        applyStimulus(32'hE5943010, 1'b1, 32'h00001000, 32'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkCtrl("ldr", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ldr.val1", val1, 32'h00001000);
        checkOutput("ldr.val2", val2, 32'h00000010);
        checkOutput("ldr.dest", {28'd0, dest}, 32'd3);

        applyStimulus(32'hE5843010, 1'b1, 32'h00001000, 32'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkCtrl("str", 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        applyStimulus(32'hE0A65007, 1'b1, 32'd66, 32'h00001234, 4'b0010, 1'b0, 1'b0, 1'b0);
        checkCtrl("adc", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("adc.val2", val2, 32'h00001234);
        checkOutput("adc.carry", {31'd0, carry}, 32'd1);
        checkOutput("adc.dest", {28'd0, dest}, 32'd5);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(32'hE0410222, 1'b1, 32'd7, 32'h80000000,
                          (k == 1) ? 4'b0010 : 4'b0000, 1'b1, 1'b0, 1'b0);
            checkOutput("freeze.exe_cmd", {28'd0, exe_cmd}, 32'd3);
            checkOutput("freeze.val1", val1, 32'd66);
            checkOutput("freeze.val2", val2, 32'h00001234);
            checkOutput("freeze.carry", {31'd0, carry}, 32'd1);
            checkOutput("freeze.out_valid", {31'd0, out_valid}, 32'd1);
        end

        applyStimulus(32'hE0410222, 1'b1, 32'd7, 32'h80000000, 4'b0000, 1'b1, 1'b1, 1'b0);
        checkBubble("flush_freeze");

        applyStimulus(32'hE3A02001, 1'b1, 32'd0, 32'd0, 4'b0010, 1'b0, 1'b0, 1'b0);
        checkCtrl("mov_imm", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("mov_imm.val2", val2, 32'd1);
        checkOutput("mov_imm.dest", {28'd0, dest}, 32'd2);

        applyStimulus(32'hE3A02001, 1'b1, 32'd0, 32'd0, 4'b0010, 1'b1, 1'b0, 1'b1);
        checkBubble("rst_mid_freeze");
        checkOutput("rst_mid_freeze.carry", {31'd0, carry}, 32'd0);

        applyStimulus(32'hEA000010, 1'b1, 32'd0, 32'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkCtrl("branch", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("branch.imm24", {8'd0, imm24}, 32'h00000010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
